// File: rtl/mux4_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux4_scan_ctrl
//
// Round-robin scan controller for a 4-channel word mux. It picks the next
// requesting channel, drives the mux select, waits SETTLE extra cycles for the
// mux output to settle, captures the selected word and holds it on a
// valid/ready output together with its channel tag. The winning source gets a
// one-cycle, one-hot ack when its word is captured.
//
// Optional build macro: MUX_SCAN_PARITY_EN
//   When defined, an extra output out_par carries the even parity (XOR) of the
//   captured word. When undefined, neither the port nor the logic exists.
//
// Parameters
//   WIDTH   data width of the mux word (default 16)
//   SETTLE  extra settle cycles between select change and capture (0..3)
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   req        in   4      per-channel data-pending request
//   mux_in     in   WIDTH  word returned by the external 4-way mux
//   sel        out  2      channel select to the external mux
//   ack        out  4      one-hot, one-cycle capture pulse to the winner
//   out_data   out  WIDTH  captured word
//   out_ch     out  2      channel index of out_data
//   out_valid  out  1      out_data/out_ch valid
//   out_par    out  1      parity of out_data (MUX_SCAN_PARITY_EN only)
//   out_ready  in   1      downstream accept (handshake on valid && ready)
// -----------------------------------------------------------------------------
module mux4_scan_ctrl #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] mux_in,
  output logic [1:0]       sel,
  output logic [3:0]       ack,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_ch,
  output logic             out_valid,
`ifdef MUX_SCAN_PARITY_EN
  output logic             out_par,
`endif
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // SETTLE is limited to 0..3, so the 2-bit counter reaches it without wrapping.
  localparam logic [1:0] SETTLE_CNT = 2'(SETTLE);

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [3:0]       ack_q, ack_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
`ifdef MUX_SCAN_PARITY_EN
  logic             out_par_q, out_par_d;
`endif

  logic             grant_valid;
  logic [1:0]       grant_ch;
  logic [1:0]       cand;
  logic             settle_done;
  logic             accept;

  // Round-robin search: start one past the last winner and take the first
  // requesting channel. Starting after last_q is what gives every held
  // request a grant within four grants, while a lone requester still wins
  // back-to-back because the search wraps round to it.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = last_q;
    cand        = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_ch    = cand;
      end
    end
  end

  assign settle_done = (cnt_q == SETTLE_CNT);
  assign accept      = out_valid_q && out_ready;

  // State register plus all registered outputs. Reset is asynchronous so an
  // in-flight scan is dropped immediately; last resets to 3 so the first
  // search after reset begins at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= 2'd0;
      last_q      <= 2'd3;
      cnt_q       <= 2'd0;
      ack_q       <= 4'd0;
      out_data_q  <= '0;
      out_ch_q    <= 2'd0;
      out_valid_q <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      out_par_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
`ifdef MUX_SCAN_PARITY_EN
      out_par_q   <= out_par_d;
`endif
    end
  end

  // Next-state logic. Requests are looked at only in IDLE; once a channel is
  // selected the capture always completes, even if its request drops.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (grant_valid) state_d = ST_WAIT;
      ST_WAIT: if (settle_done) state_d = ST_HOLD;
      ST_HOLD: if (accept)      state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic. Everything holds by default and ack falls back
  // to zero, which makes ack a single-cycle pulse issued only on capture.
  // The accept cycle returns to IDLE without arbitrating, so a new grant can
  // happen no earlier than the following edge.
  always_comb begin
    sel_d       = sel_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    ack_d       = 4'd0;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
`ifdef MUX_SCAN_PARITY_EN
    out_par_d   = out_par_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          sel_d  = grant_ch;
          last_d = grant_ch;
          cnt_d  = 2'd0;
        end
      end
      ST_WAIT: begin
        if (settle_done) begin
          out_data_d  = mux_in;
          out_ch_d    = sel_q;
          out_valid_d = 1'b1;
          ack_d       = 4'b0001 << sel_q;
`ifdef MUX_SCAN_PARITY_EN
          out_par_d   = ^mux_in;
`endif
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_HOLD: begin
        if (accept) out_valid_d = 1'b0;
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign sel       = sel_q;
  assign ack       = ack_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
`ifdef MUX_SCAN_PARITY_EN
  assign out_par   = out_par_q;
`endif

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux4_scan_ctrl
//
// Two instances share clock and reset: unit A with SETTLE=0 and unit B with
// SETTLE=2. Unit A's mux input is a small behavioural 4-way word mux driven
// by its sel; unit B's mux input is driven directly so the capture edge can
// be pinned down. Expected words are queued when a request is issued and a
// monitor pops them whenever a new word appears on the output.
// Honours MUX_SCAN_PARITY_EN for the optional out_par port.
// -----------------------------------------------------------------------------
module tb_mux4_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  int n_vec   = 0;
  int n_miss  = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic [3:0]  req_a, req_b;
  logic [15:0] mux_in_a, mux_in_b;
  logic [1:0]  sel_a, sel_b;
  logic [3:0]  ack_a, ack_b;
  logic [15:0] out_data_a, out_data_b;
  logic [1:0]  out_ch_a, out_ch_b;
  logic        out_valid_a, out_valid_b;
  logic        out_ready_a, out_ready_b;
`ifdef MUX_SCAN_PARITY_EN
  logic        out_par_a, out_par_b;
`endif

  logic [17:0] exp_q0[$];
  logic [17:0] exp_q1[$];
  bit          seen [2];

  // Behavioural word mux feeding unit A.
  function automatic logic [15:0] muxWord(input logic [1:0] s);
    case (s)
      2'd0:    muxWord = 16'h0001;
      2'd1:    muxWord = 16'h5678;
      2'd2:    muxWord = 16'hBEEF;
      default: muxWord = 16'hC0DE;
    endcase
  endfunction

  assign mux_in_a = muxWord(sel_a);

  mux4_scan_ctrl #(.WIDTH(16), .SETTLE(0)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_a),
    .mux_in    (mux_in_a),
    .sel       (sel_a),
    .ack       (ack_a),
    .out_data  (out_data_a),
    .out_ch    (out_ch_a),
    .out_valid (out_valid_a),
`ifdef MUX_SCAN_PARITY_EN
    .out_par   (out_par_a),
`endif
    .out_ready (out_ready_a)
  );

  mux4_scan_ctrl #(.WIDTH(16), .SETTLE(2)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_b),
    .mux_in    (mux_in_b),
    .sel       (sel_b),
    .ack       (ack_b),
    .out_data  (out_data_b),
    .out_ch    (out_ch_b),
    .out_valid (out_valid_b),
`ifdef MUX_SCAN_PARITY_EN
    .out_par   (out_par_b),
`endif
    .out_ready (out_ready_b)
  );

  // One comparison: counts it, reports a miscompare with both values.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req_val);
    n_vec++;
    if (act !== req_val) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, act, req_val, $time);
    end
  endtask

  // Sets a unit's request/ready inputs for the coming edges.
  task automatic applyStimulus(input int u, input logic [3:0] r, input logic rdy);
    if (u == 0) begin
      req_a       = r;
      out_ready_a = rdy;
    end else begin
      req_b       = r;
      out_ready_b = rdy;
    end
  endtask

  task automatic pushExpect(input int u, input logic [1:0] ch, input logic [15:0] d);
    if (u == 0) exp_q0.push_back({ch, d});
    else        exp_q1.push_back({ch, d});
  endtask

  // Bounded wait for out_valid on a unit; expiry counts as a failed check.
  task automatic waitValid(input int u);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (u == 0) found = (out_valid_a === 1'b1);
      else        found = (out_valid_b === 1'b1);
    end
    checkOutput("wait_valid", 32'(found), 32'd1);
  endtask

  // Monitor for one unit: a word is new on the first cycle out_valid is seen
  // after reset, after an idle cycle or after an accepted handshake.
  task automatic monitorUnit(input int u, input logic valid, input logic ready,
                             input logic [3:0] ack, input logic [15:0] data,
                             input logic [1:0] ch);
    logic [17:0] e;
    bit          have;
    if (rst_n !== 1'b1) begin
      seen[u] = 1'b0;
    end else begin
      if (valid === 1'b1 && !seen[u]) begin
        seen[u] = 1'b1;
        have    = (u == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
        if (!have) begin
          n_vec++;
          n_miss++;
          $display("[TB] FAIL unexpected_word unit %0d: got ch=%0d data=%h, required no output", u, ch, data);
        end else begin
          if (u == 0) e = exp_q0.pop_front();
          else        e = exp_q1.pop_front();
          checkOutput("mon_data", 32'(data), 32'(e[15:0]));
          checkOutput("mon_ch",   32'(ch),   32'(e[17:16]));
          checkOutput("mon_ack",  32'(ack),  32'(4'b0001 << e[17:16]));
`ifdef MUX_SCAN_PARITY_EN
          checkOutput("mon_par", 32'((u == 0) ? out_par_a : out_par_b), 32'(^e[15:0]));
`endif
        end
      end else begin
        checkOutput("ack_idle", 32'(ack), 32'd0);
      end
      if (valid !== 1'b1 || ready === 1'b1) seen[u] = 1'b0;
    end
  endtask

  // Sample one time unit after the falling edge so the ready value the bench
  // drove for the next rising edge is already in place.
  always @(negedge clk) begin
    #1;
    monitorUnit(0, out_valid_a, out_ready_a, ack_a, out_data_a, out_ch_a);
    monitorUnit(1, out_valid_b, out_ready_b, ack_b, out_data_b, out_ch_b);
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  int prev_cyc;

  initial begin
    // Reset held with all channels requesting and the clock running.
    rst_n       = 1'b0;
    req_a       = 4'hF;
    req_b       = 4'hF;
    out_ready_a = 1'b1;
    out_ready_b = 1'b1;
    mux_in_b    = 16'h0000;
    repeat (3) @(negedge clk);
    checkOutput("rst_sel",       32'(sel_a),       32'd0);
    checkOutput("rst_ack",       32'(ack_a),       32'd0);
    checkOutput("rst_out_valid", 32'(out_valid_a), 32'd0);
    checkOutput("rst_out_data",  32'(out_data_a),  32'd0);
    checkOutput("rst_out_ch",    32'(out_ch_a),    32'd0);
    checkOutput("rst_b_valid",   32'(out_valid_b), 32'd0);
    applyStimulus(0, 4'h0, 1'b1);
    applyStimulus(1, 4'h0, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // All channels held: round-robin 0,1,2,3,0, one grant every 3 cycles.
    applyStimulus(0, 4'hF, 1'b1);
    pushExpect(0, 2'd0, 16'h0001);
    pushExpect(0, 2'd1, 16'h5678);
    pushExpect(0, 2'd2, 16'hBEEF);
    pushExpect(0, 2'd3, 16'hC0DE);
    pushExpect(0, 2'd0, 16'h0001);
    prev_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      waitValid(0);
      if (k > 0) checkOutput("grant_spacing", 32'(cyc_cnt - prev_cyc), 32'd3);
      prev_cyc = cyc_cnt;
      if (k == 4) applyStimulus(0, 4'h0, 1'b1);
    end
    @(negedge clk);
    checkOutput("rr_end_valid", 32'(out_valid_a), 32'd0);

    // Single request on channel 2: sel after one edge, capture after two.
    applyStimulus(0, 4'b0100, 1'b1);
    pushExpect(0, 2'd2, 16'hBEEF);
    @(negedge clk);
    checkOutput("lat_sel",        32'(sel_a),       32'd2);
    checkOutput("lat_valid_low",  32'(out_valid_a), 32'd0);
    applyStimulus(0, 4'h0, 1'b1);
    @(negedge clk);
    checkOutput("lat_valid_high", 32'(out_valid_a), 32'd1);
    checkOutput("lat_data",       32'(out_data_a),  32'h0000BEEF);
    checkOutput("lat_ack",        32'(ack_a),       32'h4);
    @(negedge clk);
    checkOutput("lat_accepted",   32'(out_valid_a), 32'd0);
    checkOutput("lat_ack_pulse",  32'(ack_a),       32'd0);

    // Back-pressure: word, tag and sel hold for 5 cycles with no new ack.
    applyStimulus(0, 4'b0001, 1'b0);
    pushExpect(0, 2'd0, 16'h0001);
    @(negedge clk);
    checkOutput("bp_sel", 32'(sel_a), 32'd0);
    @(negedge clk);
    checkOutput("bp_valid_rise", 32'(out_valid_a), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_valid", 32'(out_valid_a), 32'd1);
      checkOutput("bp_data",  32'(out_data_a),  32'h00000001);
      checkOutput("bp_ch",    32'(out_ch_a),    32'd0);
      checkOutput("bp_sel_hold", 32'(sel_a),    32'd0);
      checkOutput("bp_ack",   32'(ack_a),       32'd0);
    end
    applyStimulus(0, 4'h0, 1'b1);
    @(negedge clk);
    checkOutput("bp_release", 32'(out_valid_a), 32'd0);

    // SETTLE=2: capture on the 4th edge takes the word present at that edge,
    // and a request dropped during WAIT still completes.
    applyStimulus(1, 4'b0010, 1'b1);
    mux_in_b = 16'h1111;
    pushExpect(1, 2'd1, 16'h2222);
    @(negedge clk);
    checkOutput("s2_sel",    32'(sel_b),       32'd1);
    checkOutput("s2_valid1", 32'(out_valid_b), 32'd0);
    applyStimulus(1, 4'h0, 1'b1);
    @(negedge clk);
    checkOutput("s2_valid2", 32'(out_valid_b), 32'd0);
    @(negedge clk);
    checkOutput("s2_valid3", 32'(out_valid_b), 32'd0);
    mux_in_b = 16'h2222;
    @(negedge clk);
    checkOutput("s2_valid4", 32'(out_valid_b), 32'd1);
    checkOutput("s2_data",   32'(out_data_b),  32'h00002222);
    @(negedge clk);
    checkOutput("s2_accepted", 32'(out_valid_b), 32'd0);
    mux_in_b = 16'h0000;

    // Reset during WAIT: immediate clear, no ack, next scan from channel 0.
    applyStimulus(0, 4'b0100, 1'b1);
    @(negedge clk);
    checkOutput("rw_sel_before", 32'(sel_a), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rw_sel_clear",   32'(sel_a),       32'd0);
    checkOutput("rw_valid_clear", 32'(out_valid_a), 32'd0);
    checkOutput("rw_ack_clear",   32'(ack_a),       32'd0);
    #1 rst_n = 1'b1;
    applyStimulus(0, 4'b1001, 1'b1);
    pushExpect(0, 2'd0, 16'h0001);
    @(negedge clk);
    checkOutput("rw_restart_sel", 32'(sel_a),       32'd0);
    checkOutput("rw_no_capture",  32'(out_valid_a), 32'd0);
    applyStimulus(0, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("rw_capture", 32'(out_valid_a), 32'd1);
`ifdef MUX_SCAN_PARITY_EN
    checkOutput("par_one", 32'(out_par_a), 32'd1);
`endif

    // Reset while a word is held: outputs clear before any clock edge.
    @(negedge clk);
    checkOutput("rh_valid_before", 32'(out_valid_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rh_valid_clear", 32'(out_valid_a), 32'd0);
    checkOutput("rh_data_clear",  32'(out_data_a),  32'd0);
    checkOutput("rh_ch_clear",    32'(out_ch_a),    32'd0);
`ifdef MUX_SCAN_PARITY_EN
    checkOutput("rh_par_clear",   32'(out_par_a),   32'd0);
`endif
    #1 rst_n = 1'b1;
    applyStimulus(0, 4'h0, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("idle_valid", 32'(out_valid_a), 32'd0);
    checkOutput("q_empty_a",  32'(exp_q0.size()), 32'd0);
    checkOutput("q_empty_b",  32'(exp_q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
